// File: rtl/color_mode_ctrl.sv
// rtl/color_mode_ctrl.sv - debounced front-panel colour mode select with start-of-frame commit
module color_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       sw_load,
    input  logic [2:0] sw_mode,
    input  logic       sof,
    output logic [2:0] color_s,
    output logic [2:0] pend_mode,
    output logic       pending,
    output logic       mode_changed
);

    localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 = next, bit 1 = prev, bit 2 = load.
    logic [2:0]       w_raw;
    logic [2:0]       r_btn_s1;
    logic [2:0]       r_btn_s2;
    logic [2:0]       r_db;
    logic [2:0]       r_db_q;
    logic [2:0]       r_evt;
    logic [CNT_W-1:0] r_cnt [3];
    logic [2:0]       r_mode_s1;
    logic [2:0]       r_mode_s2;
    logic [2:0]       r_pend;
    logic [2:0]       r_color;
    logic             r_mode_changed;
    logic             w_next_only;
    logic             w_prev_only;

    assign w_raw = {sw_load, btn_prev, btn_next};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_s1  <= '0;
            r_btn_s2  <= '0;
            r_mode_s1 <= '0;
            r_mode_s2 <= '0;
            r_db      <= '0;
            r_db_q    <= '0;
            r_evt     <= '0;
            for (int i = 0; i < 3; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_btn_s1  <= w_raw;
            r_btn_s2  <= r_btn_s1;
            r_mode_s1 <= sw_mode;
            r_mode_s2 <= r_mode_s1;
            r_db_q    <= r_db;
            // Registered rising edge: pending update lands one edge after this.
            r_evt     <= r_db & ~r_db_q;
            for (int i = 0; i < 3; i++) begin
                if (r_btn_s2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == LP_CNT_MAX) begin
                    r_db[i]  <= r_btn_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_next_only = r_evt[0] & ~r_evt[1];
    assign w_prev_only = r_evt[1] & ~r_evt[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend         <= '0;
            r_color        <= '0;
            r_mode_changed <= 1'b0;
        end else begin
            if (r_evt[2]) begin
                r_pend <= r_mode_s2;
            end else if (w_next_only) begin
                r_pend <= r_pend + 3'd1;
            end else if (w_prev_only) begin
                r_pend <= r_pend - 3'd1;
            end

            // Commit takes the pre-update pending value so a frame never mixes modes.
            if (sof) begin
                r_color        <= r_pend;
                r_mode_changed <= (r_pend != r_color);
            end else begin
                r_mode_changed <= 1'b0;
            end
        end
    end

    assign color_s      = r_color;
    assign pend_mode    = r_pend;
    assign pending      = (r_pend != r_color);
    assign mode_changed = r_mode_changed;

endmodule

// File: doc/color_mode_ctrl.md
Name: color_mode_ctrl

Overview:
Front-panel controller that produces the 3-bit colour-select code consumed by the pixel colour-modification stage. It debounces raw push-buttons and a load switch, maintains a pending mode, and commits that mode to the output only at a start-of-frame pulse, so a frame is never drawn with mixed modes. Sits between the board I/O and the VGA pixel path.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable samples needed to accept a button level change (10 ms at 50 MHz); must be >= 2
CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_next  input  1  raw button, active-high, asynchronous to clk; advances mode
btn_prev  input  1  raw button, active-high, asynchronous to clk; steps mode back
sw_load  input  1  raw switch/button, active-high; loads sw_mode into the pending mode
sw_mode  input  3  raw switch value, sampled through synchronizer
sof  input  1  start-of-frame strobe, synchronous to clk, one cycle wide
color_s  output  3  committed colour-select code (0 = passthrough; bit2/1/0 = grey to R/G/B)
pend_mode  output  3  pending mode to be committed at the next sof
pending  output  1  high while pend_mode != color_s
mode_changed  output  1  one-cycle pulse, the cycle after a commit that changed color_s

Behaviour:
- Reset (async, active-high): color_s=0, pend_mode=0, pending=0, mode_changed=0; all synchronizer flops, debounced levels and counters=0. Reset asserted mid-debounce or mid-frame discards all progress immediately.
- Synchronizers: btn_next, btn_prev, sw_load and each sw_mode bit pass through 2 flops before use.
- Debounce (per button, independent): the counter clears whenever the synchronized value equals the debounced level; otherwise it increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips on that edge and the counter clears. Glitches shorter than DEBOUNCE_CYCLES samples are ignored.
- Event = rising edge of the debounced level (debounced & ~debounced_q). Falling edges produce no event.
- Latency: with the raw input held high from edge 0, pend_mode updates on edge DEBOUNCE_CYCLES+3.
- Pending update, applied on the edge following the event cycle; priority is load > next/prev:
  - load event: pend_mode = synchronized sw_mode.
  - next only: pend_mode+1 mod 8 (7 -> 0 wrap).
  - prev only: pend_mode-1 mod 8 (0 -> 7 wrap).
  - next and prev in the same cycle: no change.
- Commit: on a cycle with sof=1, color_s <= pend_mode (value before any same-cycle pending update). An event in the same cycle still updates pend_mode, so it is committed at the following sof.
- mode_changed is registered: it is 1 in the cycle after a commit where the new color_s differs from the old value, and 0 otherwise. A commit with an unchanged value produces no pulse.
- pending is combinational: (pend_mode != color_s).
- A button held through reset release reads as a press: it produces one event after the debounce time.
- No FSM beyond the debounce and edge logic; color_s changes only on sof edges or reset.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset, then hold btn_next high -> pend_mode=1 on edge 7 after the first high sample, pending=1, color_s=0; pulse sof -> color_s=1, mode_changed=1 for one cycle, pending=0.
2. Starting from pend_mode=7, press btn_next -> pend_mode=0; from pend_mode=0, press btn_prev -> pend_mode=7 (wrap both ways).
3. Drive btn_next with 3-cycle high glitches separated by lows -> pend_mode unchanged; a 4+-cycle hold -> exactly one increment; holding for 1000 cycles -> still one increment.
4. Set sw_mode=3'b101 and press sw_load together with btn_next -> pend_mode=5 (load wins); pressing next and prev simultaneously -> no change.
5. Place a sof in the same cycle as a next event with pend_mode=2 -> color_s=2 and pend_mode=3; the next sof gives color_s=3 with a mode_changed pulse; a further sof with no change gives no pulse.
6. Assert reset asynchronously mid-debounce with color_s=6 -> all outputs 0 immediately; after release with the button still held -> one event, pend_mode=1.
